hex_digit_scan: RTL and testbench



---
 rtl/hex_digit_scan.sv | 165 ++++++++++++++++
 tb/tb_hex_digit_scan.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hex_digit_scan.sv
// Time-multiplexed hex digit scanner: frame-synchronous double buffer, guard gaps, leading-zero blanking.
// Optional blink gating of digit codes is enabled by defining HEX_SCAN_BLINK_EN.
module hex_digit_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int SHOW_CYCLES  = 50000,
  parameter int GAP_CYCLES   = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    data_valid,
  output logic                    data_ready,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    lz_blank,
`ifdef HEX_SCAN_BLINK_EN
  input  logic                    blink,
`endif
  output logic [4:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_done
);

  localparam int VAL_W   = 4 * NUM_DIGITS;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAX_CNT = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [4:0]       CODE_BLANK = 5'h10;

  typedef enum logic {S_GAP, S_SHOW} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [VAL_W-1:0]  display, display_nx;
  logic [VAL_W-1:0]  pending, pending_nx;
  logic              pend, pend_nx;
  logic              boundary;
  logic [4:0]        code_nx;
  logic [NUM_DIGITS-1:0] sel_n_nx;
  logic              done_nx;

  // A digit is blanked when suppression is on and it and everything above it is zero;
  // digit 0 always shows so that a zero value reads "0".
  function automatic logic [4:0] digit_code_f(input logic [VAL_W-1:0] val,
                                              input logic [IDX_W-1:0] i,
                                              input logic             lz);
    logic [VAL_W-1:0] upper;
    upper = val >> {i, 2'b00};
    if (lz && (i != '0) && (upper == '0))
      return CODE_BLANK;
    return {1'b0, upper[3:0]};
  endfunction

`ifdef HEX_SCAN_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
  logic [FC_W-1:0] fcnt, fcnt_nx;
  logic            phase, phase_nx;
`endif

  // Next-state: scan sequencing, handshake and frame-boundary buffer swap
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    cnt_nx     = cnt + 1'b1;
    pending_nx = pending;
    pend_nx    = pend;
    display_nx = display;
    boundary   = (state == S_SHOW) && (idx == LAST_IDX) && (cnt == SHOW_LAST);

    case (state)
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = S_SHOW;
          cnt_nx   = '0;
        end
      end
      S_SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_nx = S_GAP;
          cnt_nx   = '0;
          idx_nx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        state_nx = S_GAP;
        cnt_nx   = '0;
      end
    endcase

    // data_ready mirrors !pend, so a transfer and a consume never coincide
    if (data_valid && data_ready) begin
      pending_nx = data_in;
      pend_nx    = 1'b1;
    end else if (boundary && pend) begin
      display_nx = pending;
      pend_nx    = 1'b0;
    end

`ifdef HEX_SCAN_BLINK_EN
    fcnt_nx  = fcnt;
    phase_nx = phase;
    if (boundary) begin
      if (fcnt == FC_LAST) begin
        fcnt_nx  = '0;
        phase_nx = ~phase;
      end else begin
        fcnt_nx = fcnt + 1'b1;
      end
    end
`endif

    // Outputs are derived from the next state so they register on the same edge
    sel_n_nx = '1;
    code_nx  = CODE_BLANK;
    if (state_nx == S_SHOW) begin
      sel_n_nx[idx_nx] = 1'b0;
      code_nx          = digit_code_f(display_nx, idx_nx, lz_blank);
`ifdef HEX_SCAN_BLINK_EN
      if (blink && phase_nx)
        code_nx = CODE_BLANK;
`endif
    end
    done_nx = (state_nx == S_SHOW) && (idx_nx == LAST_IDX) && (cnt_nx == SHOW_LAST);
  end

  // Register stage: state, buffers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_GAP;
      idx         <= '0;
      cnt         <= '0;
      display     <= '0;
      pending     <= '0;
      pend        <= 1'b0;
      digit_sel_n <= '1;
      digit_code  <= CODE_BLANK;
      frame_done  <= 1'b0;
      data_ready  <= 1'b1;
`ifdef HEX_SCAN_BLINK_EN
      fcnt        <= '0;
      phase       <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      cnt         <= cnt_nx;
      display     <= display_nx;
      pending     <= pending_nx;
      pend        <= pend_nx;
      digit_sel_n <= sel_n_nx;
      digit_code  <= code_nx;
      frame_done  <= done_nx;
      data_ready  <= !pend_nx;
`ifdef HEX_SCAN_BLINK_EN
      fcnt        <= fcnt_nx;
      phase       <= phase_nx;
`endif
    end
  end

endmodule

// File: tb/tb_hex_digit_scan.sv
// Randomized self-checking bench for hex_digit_scan against a cycle-position reference model.
// Build with HEX_SCAN_BLINK_EN defined to exercise the blink port as well.
module tb_hex_digit_scan;

  localparam int ND    = 4;
  localparam int SC    = 4;
  localparam int GC    = 1;
  localparam int BF    = 2;
  localparam int SLOT  = GC + SC;
  localparam int FRAME = ND * SLOT;

`ifdef HEX_SCAN_BLINK_EN
  localparam bit BLINK_BUILD = 1'b1;
`else
  localparam bit BLINK_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [15:0] data_in = '0;
  logic        lz_blank = 1'b0;
  logic        blink = 1'b0;
  logic [4:0]  digit_code;
  logic [3:0]  digit_sel_n;
  logic        frame_done;

  always #5 clk = ~clk;

  hex_digit_scan #(
    .NUM_DIGITS  (ND),
    .SHOW_CYCLES (SC),
    .GAP_CYCLES  (GC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_in    (data_in),
    .lz_blank   (lz_blank),
`ifdef HEX_SCAN_BLINK_EN
    .blink      (blink),
`endif
    .digit_code (digit_code),
    .digit_sel_n(digit_sel_n),
    .frame_done (frame_done)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: k = cycles since the last reset edge; everything else follows from it.
  int          k;
  logic [15:0] m_disp;
  logic [15:0] m_pend_val;
  bit          m_pend;
  bit          lz_q;
  bit          blink_q;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t (k=%0d): got %h, want %h", tag, $time, k, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_sel();
    logic [3:0] v;
    v = 4'hF;
    if ((k % SLOT) >= GC)
      v[(k / SLOT) % ND] = 1'b0;
    return v;
  endfunction

  function automatic logic [4:0] exp_code();
    int slot;
    int nsig;
    slot = (k / SLOT) % ND;
    nsig = 1;
    if ((k % SLOT) < GC)
      return 5'h10;
    if (BLINK_BUILD && blink_q && (((k / FRAME) / BF) % 2 == 1))
      return 5'h10;
    for (int d = 0; d < ND; d++)
      if (m_disp[4*d +: 4] != 4'h0) nsig = d + 1;
    if (lz_q && slot >= nsig)
      return 5'h10;
    return {1'b0, m_disp[4*slot +: 4]};
  endfunction

  // Check the current cycle, apply inputs for it, advance one clock and the model.
  task automatic cyc(input bit rn, input bit dv, input logic [15:0] din, input bit lz, input bit bl);
    chk("digit_sel_n", 16'(digit_sel_n), 16'(exp_sel()));
    chk("digit_code",  16'(digit_code),  16'(exp_code()));
    chk("frame_done",  16'(frame_done),  16'((k % FRAME) == FRAME - 1));
    chk("data_ready",  16'(data_ready),  16'(!m_pend));
    rst_n      = rn;
    data_valid = dv;
    data_in    = din;
    lz_blank   = lz;
    blink      = bl;
    @(posedge clk);
    if (!rn) begin
      k          = 0;
      m_disp     = '0;
      m_pend_val = '0;
      m_pend     = 1'b0;
    end else begin
      if (dv && !m_pend) begin
        m_pend_val = din;
        m_pend     = 1'b1;
      end else if ((k % FRAME) == FRAME - 1 && m_pend) begin
        m_disp = m_pend_val;
        m_pend = 1'b0;
      end
      k++;
    end
    lz_q    = lz;
    blink_q = bl;
    #1;
  endtask

  task automatic idle(input int n, input bit lz, input bit bl);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0, lz, bl);
  endtask

  task automatic go_to(input int pos, input bit lz);
    for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) cyc(1'b1, 1'b0, 16'h0, lz, 1'b0);
  endtask

  bit          r_rn, r_dv, r_lz, r_bl;
  logic [15:0] r_din;

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    k = 0; m_disp = '0; m_pend_val = '0; m_pend = 1'b0; lz_q = 1'b0; blink_q = 1'b0;
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // idle scan of the reset value
    idle(45, 1'b0, 1'b0);

    // mid-frame load
    go_to(7, 1'b0);
    cyc(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    idle(50, 1'b0, 1'b0);

    // back-pressure: second value waits for the boundary
    go_to(3, 1'b0);
    cyc(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    for (int i = 0; i < 2 * FRAME && m_pend; i++) cyc(1'b1, 1'b1, 16'h5678, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 16'h5678, 1'b0, 1'b0);
    idle(45, 1'b0, 1'b0);

    // leading-zero suppression
    cyc(1'b1, 1'b1, 16'h00A0, 1'b1, 1'b0);
    idle(45, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    idle(45, 1'b1, 1'b0);

    // transfer on the frame_done cycle
    go_to(FRAME - 1, 1'b0);
    cyc(1'b1, 1'b1, 16'hC0DE, 1'b0, 1'b0);
    idle(45, 1'b0, 1'b0);

    // reset during S_SHOW of digit 2 with a value pending
    go_to(2 * SLOT + 1, 1'b0);
    cyc(1'b1, 1'b1, 16'h4321, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    idle(25, 1'b0, 1'b0);

    // blink over several frames
    cyc(1'b1, 1'b1, 16'h1111, 1'b0, 1'b1);
    idle(FRAME * 6, 1'b0, 1'b1);

    // randomized traffic
    r_lz = 1'b0;
    r_bl = 1'b0;
    for (int i = 0; i < 800; i++) begin
      r_rn  = ($urandom_range(0, 249) != 0);
      r_dv  = ($urandom_range(0, 5) == 0);
      r_din = 16'($urandom);
      if ($urandom_range(0, 3) == 0) r_din[15:8] = 8'h00;
      if (i % 40 == 0) r_lz = 1'($urandom_range(0, 1));
      if (i % 70 == 0) r_bl = 1'($urandom_range(0, 1));
      cyc(r_rn, r_dv, r_din, r_lz, r_bl);
    end
    idle(2, r_lz, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
